// File: rtl/txdata_framer.sv
// ---------------------------------------------------------------------------
// txdata_framer
//
// Transmit-side framer for a GTH transmitter running 8b10b with a 16-bit
// user interface. After reset, or while train_req is asserted, it sends a
// burst of comma words so the far-end comma aligner can bit-slip into
// alignment. It then passes user data and inserts one comma word per
// COMMA_PERIOD cycles so the receiver keeps that alignment.
//
// A comma word is {PAD_CHAR, COMMA_CHAR} with charisk bit 0 set. A data word
// always has charisk 0, so user data whose low byte equals COMMA_CHAR is
// still treated as data by the receiver.
//
// Ports (all on txusrclk2):
//   txusrclk2  in   TX user clock
//   rst_n      in   synchronous active-low reset
//   s_tdata    in   [15:0] user data word
//   s_tvalid   in   s_tdata is valid
//   s_tready   out  word is accepted this cycle (never depends on s_tvalid)
//   train_req  in   level request to re-enter the training burst
//   prbs_en    in   PRBS-7 test pattern select (only with TXDATA_FRAMER_PRBS_EN)
//   txdata     out  [15:0] to GT txdata
//   txctrl2    out  [7:0]  to GT charisk (8'h01 comma, 8'h00 data)
//   txctrl0    out  [15:0] tied 0
//   txctrl1    out  [15:0] tied 0
//   tx8b10ben  out  tied 1
//   link_up    out  high while in RUN
//   data_cnt   out  [31:0] accepted data words, saturating
//
// Build option: define TXDATA_FRAMER_PRBS_EN to add the prbs_en port and a
// PRBS-7 (x^7 + x^6 + 1) generator that replaces user data in RUN.
// ---------------------------------------------------------------------------
module txdata_framer #(
    parameter int unsigned COMMA_PERIOD = 256,
    parameter int unsigned TRAIN_CYCLES = 4096,
    parameter logic [7:0]  COMMA_CHAR   = 8'hBC,
    parameter logic [7:0]  PAD_CHAR     = 8'h50
) (
    input  logic        txusrclk2,
    input  logic        rst_n,
    input  logic [15:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        train_req,
`ifdef TXDATA_FRAMER_PRBS_EN
    input  logic        prbs_en,
`endif
    output logic [15:0] txdata,
    output logic [7:0]  txctrl2,
    output logic [15:0] txctrl0,
    output logic [15:0] txctrl1,
    output logic        tx8b10ben,
    output logic        link_up,
    output logic [31:0] data_cnt
);

    localparam logic [15:0] COMMA_WORD  = {PAD_CHAR, COMMA_CHAR};
    localparam logic [15:0] PERIOD_LAST = 16'(COMMA_PERIOD - 1);
    localparam logic [15:0] TRAIN_LAST  = 16'(TRAIN_CYCLES - 1);

    typedef enum logic {
        ST_TRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t      state_reg;
    logic [15:0] train_cnt_reg;
    logic [15:0] period_cnt_reg;
    logic [15:0] txdata_reg;
    logic [7:0]  txctrl2_reg;
    logic        link_up_reg;
    logic [31:0] data_cnt_reg;

    logic data_slot;
    logic prbs_active;
    logic accept;

    // A data slot is any RUN cycle other than the periodic comma slot.
    assign data_slot = (state_reg == ST_RUN) && (period_cnt_reg != PERIOD_LAST);

`ifdef TXDATA_FRAMER_PRBS_EN
    logic [6:0]  lfsr_reg;
    logic [6:0]  lfsr_chain [0:16];
    logic [15:0] prbs_word;

    assign prbs_active   = prbs_en;
    assign lfsr_chain[0] = lfsr_reg;

    // Unroll 16 serial LFSR steps per clock; the first generated bit lands
    // in the MSB of the word.
    for (genvar gi = 0; gi < 16; gi++) begin : g_prbs
        assign lfsr_chain[gi+1] = {lfsr_chain[gi][5:0],
                                   lfsr_chain[gi][6] ^ lfsr_chain[gi][5]};
        assign prbs_word[15-gi] = lfsr_chain[gi+1][0];
    end

    always_ff @(posedge txusrclk2) begin
        if (!rst_n) begin
            lfsr_reg <= 7'h7F;
        end else if (data_slot && prbs_en) begin
            lfsr_reg <= lfsr_chain[16];
        end
    end
`else
    assign prbs_active = 1'b0;
`endif

    // Gated by rst_n so nothing is accepted while reset is held.
    assign s_tready = rst_n && data_slot && !prbs_active;
    assign accept   = s_tvalid && s_tready;

    always_ff @(posedge txusrclk2) begin
        if (!rst_n) begin
            state_reg      <= ST_TRAIN;
            train_cnt_reg  <= '0;
            period_cnt_reg <= '0;
            txdata_reg     <= COMMA_WORD;
            txctrl2_reg    <= 8'h01;
            link_up_reg    <= 1'b0;
            data_cnt_reg   <= '0;
        end else begin
            // Output word: user data, PRBS, or a comma (training, comma slot,
            // or idle fill when no data is offered).
            if (accept) begin
                txdata_reg  <= s_tdata;
                txctrl2_reg <= 8'h00;
`ifdef TXDATA_FRAMER_PRBS_EN
            end else if (data_slot && prbs_en) begin
                txdata_reg  <= prbs_word;
                txctrl2_reg <= 8'h00;
`endif
            end else begin
                txdata_reg  <= COMMA_WORD;
                txctrl2_reg <= 8'h01;
            end

            if (accept && (data_cnt_reg != 32'hFFFF_FFFF)) begin
                data_cnt_reg <= data_cnt_reg + 32'd1;
            end

            case (state_reg)
                ST_TRAIN: begin
                    // train_req held high pins the burst at its start.
                    if (train_req) begin
                        train_cnt_reg <= '0;
                    end else if (train_cnt_reg == TRAIN_LAST) begin
                        state_reg      <= ST_RUN;
                        train_cnt_reg  <= '0;
                        period_cnt_reg <= '0;
                        link_up_reg    <= 1'b1;
                    end else begin
                        train_cnt_reg <= train_cnt_reg + 16'd1;
                    end
                end
                ST_RUN: begin
                    // Idle commas do not disturb the slot grid.
                    if (period_cnt_reg == PERIOD_LAST) begin
                        period_cnt_reg <= '0;
                    end else begin
                        period_cnt_reg <= period_cnt_reg + 16'd1;
                    end
                    if (train_req) begin
                        state_reg     <= ST_TRAIN;
                        train_cnt_reg <= '0;
                        link_up_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_TRAIN;
                end
            endcase
        end
    end

    assign txdata    = txdata_reg;
    assign txctrl2   = txctrl2_reg;
    assign txctrl0   = 16'h0000;
    assign txctrl1   = 16'h0000;
    assign tx8b10ben = 1'b1;
    assign link_up   = link_up_reg;
    assign data_cnt  = data_cnt_reg;

endmodule

// File: tb/tb_txdata_framer.sv
// ---------------------------------------------------------------------------
// Directed bench for txdata_framer with TRAIN_CYCLES=16, COMMA_PERIOD=8.
// The bench tracks the expected comma-slot position itself and checks every
// transmitted word, s_tready, link_up and data_cnt against hand values.
// ---------------------------------------------------------------------------
module tb_txdata_framer;

    localparam int          CP    = 8;
    localparam int          TC    = 16;
    localparam logic [15:0] COMMA = 16'h50BC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        train_req;
    logic [15:0] txdata;
    logic [7:0]  txctrl2;
    logic [15:0] txctrl0;
    logic [15:0] txctrl1;
    logic        tx8b10ben;
    logic        link_up;
    logic [31:0] data_cnt;

    int          n_checks = 0;
    int          n_err    = 0;
    int          slot     = 0;
    logic [31:0] exp_cnt  = 0;
    logic [15:0] next_data = 16'h0001;
    logic        acc;

    always #5 clk = ~clk;

    txdata_framer #(
        .COMMA_PERIOD(CP),
        .TRAIN_CYCLES(TC)
    ) dut (
        .txusrclk2(clk),
        .rst_n    (rst_n),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .train_req(train_req),
        .txdata   (txdata),
        .txctrl2  (txctrl2),
        .txctrl0  (txctrl0),
        .txctrl1  (txctrl1),
        .tx8b10ben(tx8b10ben),
        .link_up  (link_up),
        .data_cnt (data_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One RUN cycle: offer (v, d), then check the word sent one cycle later.
    task automatic step(input logic v, input logic [15:0] d, output logic accepted);
        logic rdy;
        rdy = (slot != CP - 1);
        check("tready", {31'd0, s_tready}, {31'd0, rdy});
        s_tvalid = v;
        s_tdata  = d;
        @(posedge clk);
        #1;
        accepted = v && rdy;
        if (accepted) begin
            check("txdata_data", {16'd0, txdata}, {16'd0, d});
            check("txctrl2_data", {24'd0, txctrl2}, 32'h00);
            exp_cnt++;
        end else begin
            check("txdata_comma", {16'd0, txdata}, {16'd0, COMMA});
            check("txctrl2_comma", {24'd0, txctrl2}, 32'h01);
        end
        slot = (slot == CP - 1) ? 0 : slot + 1;
        $display("step v=%0b d=%04h acc=%0b txdata=%04h txctrl2=%02h", v, d, accepted, txdata, txctrl2);
    endtask

    task automatic stream(input int n);
        logic a;
        for (int i = 0; i < n; i++) begin
            step(1'b1, next_data, a);
            if (a) next_data++;
        end
    endtask

    // Called while the DUT sits in TRAIN at count 0 with train_req low.
    task automatic train_seq(input string tag);
        for (int i = 0; i < TC; i++) begin
            check({tag, "_link"}, {31'd0, link_up}, 32'd0);
            check({tag, "_tready"}, {31'd0, s_tready}, 32'd0);
            @(posedge clk);
            #1;
            check({tag, "_comma"}, {8'd0, txctrl2, txdata}, {8'd0, 8'h01, COMMA});
        end
        check({tag, "_link_up"}, {31'd0, link_up}, 32'd1);
        $display("train %s done link_up=%0b", tag, link_up);
        slot = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        s_tvalid  = 1'b0;
        s_tdata   = 16'h0000;
        train_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_txdata", {16'd0, txdata}, {16'd0, COMMA});
        check("rst_txctrl2", {24'd0, txctrl2}, 32'h01);
        check("rst_tready", {31'd0, s_tready}, 32'd0);
        check("rst_link_up", {31'd0, link_up}, 32'd0);
        check("rst_data_cnt", data_cnt, 32'd0);
        check("txctrl0", {16'd0, txctrl0}, 32'd0);
        check("txctrl1", {16'd0, txctrl1}, 32'd0);
        check("tx8b10ben", {31'd0, tx8b10ben}, 32'd1);
        rst_n = 1'b1;
        train_seq("train_rst");

        // Two full periods of back-to-back data.
        stream(2 * CP);
        check("cnt_2periods", data_cnt, 32'd14);

        // Three idle cycles mid-period; comma slot must not move.
        stream(2);
        for (int i = 0; i < 3; i++) step(1'b0, 16'hDEAD, acc);
        stream(3);
        check("cnt_idle", data_cnt, 32'd18);

        // Data word that looks like a comma byte is sent as data.
        step(1'b1, 16'h12BC, acc);
        check("cnt_12bc", data_cnt, 32'd19);

        // train_req pulse on the edge where 0xAAAA is accepted.
        train_req = 1'b1;
        step(1'b1, 16'hAAAA, acc);
        check("treq_link_down", {31'd0, link_up}, 32'd0);
        train_req = 1'b0;
        s_tvalid  = 1'b1;
        s_tdata   = 16'h7777;
        train_seq("train_req");
        check("cnt_after_treq", data_cnt, 32'd20);

        // train_req held for several cycles keeps the burst at its start.
        train_req = 1'b1;
        step(1'b0, 16'h0000, acc);
        for (int i = 0; i < 3; i++) begin
            check("hold_link", {31'd0, link_up}, 32'd0);
            check("hold_tready", {31'd0, s_tready}, 32'd0);
            @(posedge clk);
            #1;
        end
        train_req = 1'b0;
        train_seq("train_hold");
        stream(CP);
        check("cnt_after_hold", data_cnt, 32'd27);
        check("cnt_model", data_cnt, exp_cnt);

        // One-cycle reset in the middle of a data stream.
        stream(5);
        rst_n    = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 16'h5555;
        @(posedge clk);
        #1;
        check("mid_rst_txdata", {8'd0, txctrl2, txdata}, {8'd0, 8'h01, COMMA});
        check("mid_rst_data_cnt", data_cnt, 32'd0);
        check("mid_rst_link_up", {31'd0, link_up}, 32'd0);
        check("mid_rst_tready", {31'd0, s_tready}, 32'd0);
        rst_n   = 1'b1;
        exp_cnt = 0;
        train_seq("train_rst2");
        stream(CP);
        check("cnt_after_rst", data_cnt, 32'd7);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/txdata_framer.md
Name: txdata_framer

Overview:
Transmit-side companion to the receive comma aligner. Frames a 16-bit user word stream for the GTH transmitter with 8b10b enabled. After reset, or on request, it sends a training burst of comma words. It then inserts one comma word at a fixed period so the far-end receiver can bit-slip to, and hold, alignment. Sits between the TX application datapath and the GT TX user ports on txusrclk2.

Parameters:
COMMA_PERIOD, 256, cycles per comma slot in RUN (legal range 2..65535; one slot per period).
TRAIN_CYCLES, 4096, comma words sent in TRAIN before entering RUN (legal range 1..65535).
COMMA_CHAR, 8'hBC, K28.5 comma byte, sent in the low byte with its control bit set.
PAD_CHAR, 8'h50, D16.2 byte, sent in the high byte of every comma word.

Ports:
txusrclk2  input  1  TX user clock; all logic is on this clock.
rst_n  input  1  reset, synchronous, active-low.
s_tdata  input  16  user data word.
s_tvalid  input  1  s_tdata is valid.
s_tready  output  1  framer accepts the word this cycle.
train_req  input  1  level request to re-enter TRAIN, e.g. far end lost alignment.
txdata  output  16  to GT txdata[15:0].
txctrl2  output  8  to GT charisk; 8'h01 for a comma word, 8'h00 for data.
txctrl0  output  16  tied 0.
txctrl1  output  16  tied 0.
tx8b10ben  output  1  tied 1.
link_up  output  1  high while in RUN.
data_cnt  output  32  count of accepted data words, saturates at all-ones.

Behaviour:
- Reset (rst_n low at an edge):
  - state=TRAIN; train/period counters=0; data_cnt=0; link_up=0.
  - txdata={PAD_CHAR,COMMA_CHAR}=16'h50BC; txctrl2=8'h01.
  - s_tready=0 during reset.
- Timing:
  - txdata, txctrl2, link_up and data_cnt are registered.
  - Latency from accept to txdata is 1 cycle.
  - s_tready is combinational from registered state/counters only; it never depends on s_tvalid.
- Handshake:
  - A transfer happens when s_tvalid & s_tready are both high at a rising edge.
  - The accepted word appears on txdata with txctrl2=0 on the next cycle.
  - Data words with low byte 8'hBC are legal; the ctrl bit distinguishes them from commas.
- TRAIN state:
  - Comma word every cycle; s_tready=0.
  - train_cnt counts 0..TRAIN_CYCLES-1. At TRAIN_CYCLES-1 the next state is RUN and period_cnt is cleared.
  - Exactly TRAIN_CYCLES comma words are driven after reset release before the first possible data word.
- RUN state:
  - period_cnt wraps 0..COMMA_PERIOD-1 continuously.
  - Cycle with period_cnt==COMMA_PERIOD-1 is the comma slot: s_tready=0, comma word sent.
  - Other cycles: s_tready=1. Send the accepted data word; if s_tvalid=0, send an idle comma word. Idle commas do not reset period_cnt.
  - link_up=1.
- train_req:
  - Sampled at each edge. When high in any state, the next state is TRAIN with train_cnt=0 and link_up=0.
  - A word accepted on the same edge is still sent, one cycle later.
  - While train_req stays high, train_cnt holds at 0 and TRAIN persists. TRAIN_CYCLES are counted from the first cycle it is low.
- data_cnt:
  - Increments per transfer and saturates at 32'hFFFFFFFF.
  - Cleared only by reset; train_req does not clear it.
- Counter widths: 16 bits each; no wrap other than those defined above.
- Reset mid-transfer: a pending accepted word is discarded and the reset values apply on the next cycle.

Optional Feature:
Macro TXDATA_FRAMER_PRBS_EN.
- When defined, adds input port prbs_en (1 bit).
  - While prbs_en=1 in RUN, data cycles ignore s_tdata and send PRBS-7 (x^7+x^6+1), 16 bits per cycle, seed 7'h7F on reset, with txctrl2=0.
  - s_tready stays 0 in PRBS mode, except that comma slots remain unchanged.
  - data_cnt does not increment.
  - The LFSR advances only on data cycles.
- When not defined: no prbs_en port and no LFSR logic; behaviour is as described above.

Test Plan:
- Reset, TRAIN_CYCLES=16 -> exactly 16 cycles of txdata=16'h50BC/txctrl2=8'h01, s_tready=0, link_up=0; then link_up=1.
- RUN, COMMA_PERIOD=8, s_tvalid=1 with incrementing data 0x0001.. -> 7 data words (txctrl2=0) then 1 comma, repeating; no word lost or duplicated; data_cnt=7 per period.
- s_tvalid=0 for 3 cycles mid-period -> 3 idle commas (16'h50BC, 8'h01); comma slot position unchanged.
- s_tdata=16'h12BC accepted -> txdata=16'h12BC with txctrl2=8'h00.
- train_req pulse 1 cycle on an edge where 0xAAAA is accepted -> 0xAAAA sent next cycle; then 16 commas; link_up low for 16 cycles.
- rst_n low for 1 cycle during RUN with data flowing -> next cycle 16'h50BC/8'h01, data_cnt=0, TRAIN restarts.
